// File: rtl/mips_mc_if.sv
// ---------------------------------------------------------------------------
// mips_mc_if
//
// Bundles the signals between the multi-cycle MIPS control FSM and the
// datapath / unified memory it steers.
//
//   master (control FSM) : receives op, zero
//                          drives mem_we, iord, ir_write, pc_en, pc_src,
//                          reg_write, reg_dst, mem_to_reg, alu_src_a,
//                          alu_src_b, alu_op, illegal, state
//   slave  (datapath)    : the mirror image of master
// ---------------------------------------------------------------------------
interface mips_mc_if;
    logic [5:0] op;          // instr[31:26] from the instruction register
    logic       zero;        // ALU zero flag
    logic       mem_we;      // unified memory write enable
    logic       iord;        // memory address select: 0 = PC, 1 = ALUOut
    logic       ir_write;    // instruction register load strobe
    logic       pc_en;       // PC load enable
    logic [1:0] pc_src;      // 00 ALU result, 01 ALUOut, 10 jump target
    logic       reg_write;   // register-file write enable
    logic       reg_dst;     // 0 = rt, 1 = rd
    logic       mem_to_reg;  // 0 = ALUOut, 1 = memory data register
    logic       alu_src_a;   // 0 = PC, 1 = register A
    logic [1:0] alu_src_b;   // 00 B, 01 const 4, 10 sext imm, 11 sext imm << 2
    logic [1:0] alu_op;      // 00 add, 01 sub, 10 decode funct
    logic       illegal;     // one-cycle pulse in DECODE on unsupported op
    logic [3:0] state;       // current state encoding, for debug

    modport master (
        input  op, zero,
        output mem_we, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, state
    );

    modport slave (
        output op, zero,
        input  mem_we, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, state
    );
endinterface

// File: rtl/mips_mc_control.sv
// ---------------------------------------------------------------------------
// mips_mc_control
//
// Main control FSM of the multi-cycle MIPS datapath. Every instruction is
// walked through fetch / decode / execute / memory / writeback states; the
// datapath and memory controls are Moore-decoded from the state register and
// the memory wait counter (pc_en additionally folds in the ALU zero flag).
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; forces FETCH and zeroes every output
//            while asserted (an in-flight MEMWRITE is aborted with no write)
//   bus    : mips_mc_if.master -- op/zero in, all control strobes out
//
// Parameters:
//   MEM_WAIT : extra stall cycles in each memory-access state
//              (FETCH, MEMREAD, MEMWRITE), 0..15
//
// Build option:
//   MIPS_MC_BNE_EN : when defined, opcode 000101 (bne) is supported and
//                    shares the BRANCH state with beq using an inverted
//                    zero test; when undefined, 000101 decodes as illegal.
// ---------------------------------------------------------------------------
module mips_mc_control #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    mips_mc_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    // Control word produced by the state decoder. pc_write and branch are
    // internal and are merged into pc_en below.
    typedef struct packed {
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctl_t;

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    ctl_t       ctl;
    logic       access_done;
    logic       branch_cond;

    // A memory-access state finishes once the counter has reached MEM_WAIT.
    assign access_done = (wait_q == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef MIPS_MC_BNE_EN
    // Remembers whether the branch being executed is bne. The IR is stable
    // in DECODE, so this is the single place the opcode is captured.
    logic bne_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bne_q <= 1'b0;
        end else if (state_q == DECODE) begin
            bne_q <= (bus.op == OP_BNE);
        end
    end

    assign branch_cond = bne_q ? ~bus.zero : bus.zero;
`else
    assign branch_cond = bus.zero;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;          // leaving a state always clears the counter
        ctl     = '0;

        case (state_q)
            FETCH: begin
                ctl.alu_src_b = 2'b01;
                if (access_done) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            DECODE: begin
                ctl.alu_src_b = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_d     = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end

            MEMREAD: begin
                ctl.iord = 1'b1;
                if (access_done) begin
                    state_d = MEMWB;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end

            MEMWRITE: begin
                ctl.iord = 1'b1;
                // Single write pulse on the final cycle of the access.
                if (access_done) begin
                    ctl.mem_we = 1'b1;
                    state_d    = FETCH;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            EXECUTE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                state_d       = ALUWB;
            end

            ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_d       = FETCH;
            end

            BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b01;
                ctl.pc_src    = 2'b01;
                ctl.branch    = 1'b1;
                state_d       = FETCH;
            end

            ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = ADDIWB;
            end

            ADDIWB: begin
                ctl.reg_write = 1'b1;
                state_d       = FETCH;
            end

            JUMP: begin
                ctl.pc_src   = 2'b10;
                ctl.pc_write = 1'b1;
                state_d      = FETCH;
            end

            default: state_d = FETCH;   // codes 12..15 recover to FETCH
        endcase
    end

    // Outputs are forced low while reset is held, so a MEMWRITE caught by
    // reset never produces a write strobe.
    assign bus.mem_we     = ~reset & ctl.mem_we;
    assign bus.iord       = ~reset & ctl.iord;
    assign bus.ir_write   = ~reset & ctl.ir_write;
    assign bus.pc_en      = ~reset & (ctl.pc_write | (ctl.branch & branch_cond));
    assign bus.pc_src     = reset ? 2'b00 : ctl.pc_src;
    assign bus.reg_write  = ~reset & ctl.reg_write;
    assign bus.reg_dst    = ~reset & ctl.reg_dst;
    assign bus.mem_to_reg = ~reset & ctl.mem_to_reg;
    assign bus.alu_src_a  = ~reset & ctl.alu_src_a;
    assign bus.alu_src_b  = reset ? 2'b00 : ctl.alu_src_b;
    assign bus.alu_op     = reset ? 2'b00 : ctl.alu_op;
    assign bus.illegal    = ~reset & ctl.illegal;
    assign bus.state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_control
//
// Two instances: dut0 with MEM_WAIT=0 and dut1 with MEM_WAIT=2. The stimulus
// process drives opcodes and, for every cycle it cares about, pushes the
// hand-computed control word expected at that cycle into a per-DUT queue.
// Independent monitors on the falling edge pop entries due in the current
// cycle and compare them against the DUT outputs.
//
// Control word layout (19 bits, MSB first):
//   mem_we iord ir_write pc_en pc_src[1:0] reg_write reg_dst mem_to_reg
//   alu_src_a alu_src_b[1:0] alu_op[1:0] illegal state[3:0]
// ---------------------------------------------------------------------------
module tb_mips_mc_control;

    typedef logic [18:0] word_t;

    typedef struct {
        int    cyc;
        word_t word;
        string tag;
    } exp_t;

    // Expected words per state, written straight from the state table.
    localparam word_t W_RST   = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,4'd0};
    localparam word_t F_WAIT  = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,4'd0};
    localparam word_t F_LAST  = {1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,4'd0};
    localparam word_t DEC     = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,4'd1};
    localparam word_t DEC_ILL = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b1,4'd1};
    localparam word_t MADR    = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,4'd2};
    localparam word_t MRD     = {1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,4'd3};
    localparam word_t MWB     = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,4'd4};
    localparam word_t MW_WAIT = {1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,4'd5};
    localparam word_t MW_LAST = {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,4'd5};
    localparam word_t EXEC    = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,4'd6};
    localparam word_t ALUWB   = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,4'd7};
    localparam word_t BR_T    = {1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,4'd8};
    localparam word_t BR_N    = {1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,4'd8};
    localparam word_t ADDIEX  = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,4'd9};
    localparam word_t ADDIWB  = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,4'd10};
    localparam word_t JMP     = {1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,4'd11};

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic clk = 1'b0;
    logic reset0;
    logic reset1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0;
    exp_t e1;

    mips_mc_if if0 ();
    mips_mc_if if1 ();

    mips_mc_control #(.MEM_WAIT(0)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (if0)
    );

    mips_mc_control #(.MEM_WAIT(2)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    word_t act0;
    word_t act1;
    assign act0 = {if0.mem_we, if0.iord, if0.ir_write, if0.pc_en, if0.pc_src,
                   if0.reg_write, if0.reg_dst, if0.mem_to_reg, if0.alu_src_a,
                   if0.alu_src_b, if0.alu_op, if0.illegal, if0.state};
    assign act1 = {if1.mem_we, if1.iord, if1.ir_write, if1.pc_en, if1.pc_src,
                   if1.reg_write, if1.reg_dst, if1.mem_to_reg, if1.alu_src_a,
                   if1.alu_src_b, if1.alu_op, if1.illegal, if1.state};

    task automatic check(input string name, input int at, input word_t got, input word_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %05h expected %05h", name, at, got, want);
        end
    endtask

    // Monitors: compare every expectation that has come due this cycle.
    always @(negedge clk) begin
        while (sb0.size() != 0 && sb0[0].cyc <= cyc) begin
            e0 = sb0.pop_front();
            check({"dut0_", e0.tag}, cyc, act0, e0.word);
        end
    end

    always @(negedge clk) begin
        while (sb1.size() != 0 && sb1[0].cyc <= cyc) begin
            e1 = sb1.pop_front();
            check({"dut1_", e1.tag}, cyc, act1, e1.word);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push0(input int off, input word_t w, input string tag);
        exp_t e;
        e.cyc  = cyc + off;
        e.word = w;
        e.tag  = tag;
        sb0.push_back(e);
    endtask

    task automatic push1(input int off, input word_t w, input string tag);
        exp_t e;
        e.cyc  = cyc + off;
        e.word = w;
        e.tag  = tag;
        sb1.push_back(e);
    endtask

    initial begin
        reset0   = 1'b1;
        reset1   = 1'b1;
        if0.op   = OP_LW;
        if0.zero = 1'b0;
        if1.op   = OP_LW;
        if1.zero = 1'b0;

        // Reset held for two checked cycles with a lw opcode present.
        step(1); push0(0, W_RST, "reset_a");
        step(1); push0(0, W_RST, "reset_b");
        step(1); reset0 = 1'b0;

        // lw: 0,1,2,3,4
        push0(0, F_LAST, "lw_fetch"); push0(1, DEC, "lw_decode");
        push0(2, MADR, "lw_memadr");  push0(3, MRD, "lw_memread");
        push0(4, MWB, "lw_memwb");
        step(5);

        // sw: 0,1,2,5 with one write pulse
        if0.op = OP_SW;
        push0(0, F_LAST, "sw_fetch"); push0(1, DEC, "sw_decode");
        push0(2, MADR, "sw_memadr");  push0(3, MW_LAST, "sw_memwrite");
        step(4);

        // sw aborted by reset while in MEMWRITE: no write strobe
        push0(0, F_LAST, "swab_fetch"); push0(1, DEC, "swab_decode");
        push0(2, MADR, "swab_memadr");
        step(3);
        reset0 = 1'b1;
        push0(0, W_RST, "swab_reset");
        step(1);
        reset0 = 1'b0;

        // R-type: 0,1,6,7 (first word also proves the abort landed in FETCH)
        if0.op = OP_RTYPE;
        push0(0, F_LAST, "r_fetch_after_abort"); push0(1, DEC, "r_decode");
        push0(2, EXEC, "r_execute");             push0(3, ALUWB, "r_aluwb");
        step(4);

        // addi: 0,1,9,10
        if0.op = OP_ADDI;
        push0(0, F_LAST, "addi_fetch"); push0(1, DEC, "addi_decode");
        push0(2, ADDIEX, "addi_ex");    push0(3, ADDIWB, "addi_wb");
        step(4);

        // beq taken / not taken
        if0.op = OP_BEQ; if0.zero = 1'b1;
        push0(0, F_LAST, "beq1_fetch"); push0(1, DEC, "beq1_decode");
        push0(2, BR_T, "beq_taken");
        step(3);
        if0.zero = 1'b0;
        push0(0, F_LAST, "beq0_fetch"); push0(1, DEC, "beq0_decode");
        push0(2, BR_N, "beq_not_taken");
        step(3);

        // j: 0,1,11
        if0.op = OP_J;
        push0(0, F_LAST, "j_fetch"); push0(1, DEC, "j_decode");
        push0(2, JMP, "j_jump");
        step(3);

        // illegal opcode: 0,1,0 with one illegal pulse
        if0.op = OP_BAD;
        push0(0, F_LAST, "ill_fetch"); push0(1, DEC_ILL, "ill_decode");
        step(2);

        // bne opcode, zero=0
        if0.op = OP_BNE;
`ifdef MIPS_MC_BNE_EN
        push0(0, F_LAST, "bne0_fetch"); push0(1, DEC, "bne0_decode");
        push0(2, BR_T, "bne_taken");
        step(3);
        if0.zero = 1'b1;
        push0(0, F_LAST, "bne1_fetch"); push0(1, DEC, "bne1_decode");
        push0(2, BR_N, "bne_not_taken");
        step(3);
`else
        push0(0, F_LAST, "bne_fetch"); push0(1, DEC_ILL, "bne_illegal");
        step(2);
`endif

        // beq after bne: flag must not stick
        if0.op = OP_BEQ; if0.zero = 1'b1;
        push0(0, F_LAST, "beq2_fetch"); push0(1, DEC, "beq2_decode");
        push0(2, BR_T, "beq2_taken");
        step(3);
        if0.op = OP_RTYPE;
        push0(0, F_LAST, "idle_fetch");
        step(1);

        // dut1, MEM_WAIT=2: lw takes 9 cycles, sw takes 8
        reset1 = 1'b0;
        push1(0, F_WAIT, "lw_fetch_w0"); push1(1, F_WAIT, "lw_fetch_w1");
        push1(2, F_LAST, "lw_fetch_last"); push1(3, DEC, "lw_decode");
        push1(4, MADR, "lw_memadr");     push1(5, MRD, "lw_memread_w0");
        push1(6, MRD, "lw_memread_w1");  push1(7, MRD, "lw_memread_last");
        push1(8, MWB, "lw_memwb");
        step(9);
        if1.op = OP_SW;
        push1(0, F_WAIT, "sw_fetch_w0"); push1(1, F_WAIT, "sw_fetch_w1");
        push1(2, F_LAST, "sw_fetch_last"); push1(3, DEC, "sw_decode");
        push1(4, MADR, "sw_memadr");     push1(5, MW_WAIT, "sw_memwrite_w0");
        push1(6, MW_WAIT, "sw_memwrite_w1"); push1(7, MW_LAST, "sw_memwrite_last");
        step(8);
        push1(0, F_WAIT, "next_fetch_w0");
        step(2);

        // Every queued expectation must have been consumed by a monitor.
        n_checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0",
                     sb0.size(), sb1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
